seg_msg_sequencer: RTL and testbench

Parametrised seven-segment message sequencer. It is the successor to the team's fixed-text scrolling display. It holds a writable message memory of segment patterns and plays it out on an 8-bit segment bus ({dp,a..g}, bit 7 = dp). Playback rate is programmable, and it supports loop, one-shot, bounce and reverse modes plus pause and stop. It sits between the tile's dedicated inputs/bidirectional pins (load and control path) and the dedicated outputs driving the display.

---
 rtl/seg_msg_if.sv | 31 +++
 rtl/seg_msg_sequencer.sv | 131 +++++++++++++
 tb/tb_seg_msg_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_msg_if.sv
// Load/control and display-drive bundle for seg_msg_sequencer.
// The master side is the controller; the slave side is the sequencer.
interface seg_msg_if #(
  parameter int AW      = 4,
  parameter int PRESC_W = 16
);
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [7:0]         wr_data;
  logic               wr_ready;
  logic               start;
  logic               stop;
  logic               pause;
  logic [1:0]         mode;
  logic [AW-1:0]      last;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         seg_out;
  logic [AW-1:0]      index;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, pause, mode, last, presc,
    input  wr_ready, seg_out, index, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, pause, mode, last, presc,
    output wr_ready, seg_out, index, busy, done
  );
endinterface

// File: rtl/seg_msg_sequencer.sv
// Seven-segment message sequencer: writable pattern memory played out on {dp,a..g}
// with loop, one-shot, bounce and reverse modes, programmable dwell, pause and stop.
module seg_msg_sequencer #(
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 16
) (
  input logic    clk,
  input logic    rst,
  seg_msg_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  logic [1:0]         mode_reg;
  logic [AW-1:0]      last_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] count_reg;
  logic [AW-1:0]      index_reg;
  logic               down_reg;
  logic [7:0]         seg_reg;
  logic               done_reg;

  logic [7:0]         mem [DEPTH];

  logic               wr_accept;
  logic [AW-1:0]      first_idx;
  logic [7:0]         first_seg;
  logic [AW-1:0]      step_idx;
  logic               step_down;

  assign wr_accept = bus.wr_en && (state_reg == IDLE);

  // Cleared on reset so a replay after reset shows blanks, hence plain registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_accept) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    first_idx = (bus.mode == 2'b11) ? bus.last : '0;
    // A write landing on the first entry in the start cycle is shown immediately.
    first_seg = (wr_accept && bus.wr_addr == first_idx) ? bus.wr_data : mem[first_idx];

    step_idx  = index_reg + AW'(1);
    step_down = down_reg;
    case (mode_reg)
      2'b00: step_idx = (index_reg == last_reg) ? '0 : index_reg + AW'(1);
      2'b01: step_idx = index_reg + AW'(1);
      2'b10: begin
        if (last_reg == '0) begin
          step_idx  = '0;
          step_down = 1'b0;
        end else if (!down_reg) begin
          if (index_reg == last_reg) begin
            step_idx  = index_reg - AW'(1);
            step_down = 1'b1;
          end else begin
            step_idx = index_reg + AW'(1);
          end
        end else begin
          if (index_reg == '0) begin
            step_idx  = index_reg + AW'(1);
            step_down = 1'b0;
          end else begin
            step_idx = index_reg - AW'(1);
          end
        end
      end
      default: step_idx = (index_reg == '0) ? last_reg : index_reg - AW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= 2'b00;
      last_reg  <= '0;
      presc_reg <= '0;
      count_reg <= '0;
      index_reg <= '0;
      down_reg  <= 1'b0;
      seg_reg   <= 8'h00;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.stop) begin
        state_reg <= IDLE;
        count_reg <= '0;
        index_reg <= '0;
        down_reg  <= 1'b0;
        seg_reg   <= 8'h00;
      end else if (bus.start) begin
        mode_reg  <= bus.mode;
        last_reg  <= bus.last;
        presc_reg <= bus.presc;
        count_reg <= '0;
        down_reg  <= (bus.mode == 2'b11);
        index_reg <= first_idx;
        seg_reg   <= first_seg;
        state_reg <= RUN;
      end else if (state_reg == RUN && !bus.pause) begin
        if (count_reg != presc_reg) begin
          count_reg <= count_reg + PRESC_W'(1);
        end else begin
          count_reg <= '0;
          if (mode_reg == 2'b01 && index_reg == last_reg) begin
            state_reg <= IDLE;
            index_reg <= '0;
            seg_reg   <= 8'h00;
            done_reg  <= 1'b1;
          end else begin
            index_reg <= step_idx;
            down_reg  <= step_down;
            seg_reg   <= mem[step_idx];
          end
        end
      end
    end
  end

  assign bus.wr_ready = (state_reg == IDLE);
  assign bus.busy     = (state_reg == RUN);
  assign bus.seg_out  = seg_reg;
  assign bus.index    = index_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Scoreboard bench for seg_msg_sequencer: expected {seg,index,busy,done} are queued
// as each cycle's stimulus is driven and compared once the DUT has clocked it.
module tb_seg_msg_sequencer;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int PRESC_W = 16;

  typedef struct packed {
    logic [7:0]    seg;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  obs_t exp_q[$];
  logic [7:0] mem_model [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_msg_if #(.AW(AW), .PRESC_W(PRESC_W)) bus ();

  seg_msg_sequencer #(.DEPTH(DEPTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic obs_t mk(logic [7:0] seg, int idx, logic busy, logic done);
    obs_t r;
    r.seg = seg; r.idx = AW'(idx); r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic write_word(input int addr, input logic [7:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(addr); bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    mem_model[addr] = data;
    $display("write addr=%0d data=%h", addr, data);
  endtask

  task automatic set_start(input logic [1:0] mode, input int last, input int presc);
    bus.start = 1'b1; bus.mode = mode; bus.last = AW'(last); bus.presc = PRESC_W'(presc);
    $display("start mode=%0d last=%0d presc=%0d", mode, last, presc);
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.stop = 0;
    bus.pause = 0; bus.mode = '0; bus.last = '0; bus.presc = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(8'h00, 0, 1'b0, 1'b0));
      if (k == 1) begin rst = 1'b0; @(posedge clk); #1; end
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    checks++;
    if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_loop();
    obs_t e, o;
    write_word(0, 8'h5B); write_word(1, 8'h4F); write_word(2, 8'h15);
    set_start(2'b00, 2, 3);
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back(mk(mem_model[(k / 4) % 3], (k / 4) % 3, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      // Writes while running must not reach the memory.
      bus.wr_en = (k >= 1 && k < 6); bus.wr_addr = AW'(k % 3); bus.wr_data = 8'hFF;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL loop k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    checks++;
    if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL loop_wr_ready got %b want 0", bus.wr_ready); end
    bus.stop = 1'b1;
    exp_q.push_back(mk(8'h00, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.stop = 1'b0;
    e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL loop_stop got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
               o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
    end
  endtask

  task automatic test_oneshot();
    obs_t e, o;
    set_start(2'b01, 2, 0);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) exp_q.push_back(mk(mem_model[k], k, 1'b1, 1'b0));
      else       exp_q.push_back(mk(8'h00, 0, 1'b0, k == 3));
      @(posedge clk); #1;
      bus.start = 1'b0;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL oneshot k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    checks++;
    if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL oneshot_wr_ready got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_bounce();
    obs_t e, o;
    int p;
    write_word(3, 8'h06);
    set_start(2'b10, 3, 0);
    for (int k = 0; k < 14; k++) begin
      p = k % 6;
      p = (p <= 3) ? p : 6 - p;
      exp_q.push_back(mk(mem_model[p], p, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bounce k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    // Restart from RUN with a single-entry message.
    set_start(2'b10, 0, 0);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(mk(mem_model[0], 0, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bounce_last0 k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic test_reverse_pause();
    obs_t e, o;
    int pos = 0;
    int ix;
    set_start(2'b11, 2, 1);
    for (int k = 0; k < 20; k++) begin
      // pos counts unpaused edges since start; each entry takes two of them.
      if (k > 0) begin
        bus.pause = (k >= 4 && k <= 8);
        if (!bus.pause) pos++;
      end
      ix = 2 - ((pos / 2) % 3);
      exp_q.push_back(mk(mem_model[ix], ix, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reverse_pause k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    bus.pause = 1'b0;
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic test_stop_start();
    obs_t e, o;
    set_start(2'b00, 2, 3);
    for (int k = 0; k < 8; k++) begin
      if (k < 3)       exp_q.push_back(mk(mem_model[0], 0, 1'b1, 1'b0));
      else if (k < 5)  exp_q.push_back(mk(8'h00, 0, 1'b0, 1'b0));
      else             exp_q.push_back(mk(8'h7E, 0, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0; bus.stop = 1'b0;
      if (k == 2) begin bus.stop = 1'b1; bus.start = 1'b1; end
      if (k == 4) begin
        set_start(2'b00, 2, 3);
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 8'h7E;
        mem_model[0] = 8'h7E;
      end
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop_start k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    // Continue the restarted playback: entries 0 (already 3 cycles shown), then 1.
    for (int k = 3; k < 8; k++) begin
      exp_q.push_back(mk(mem_model[(k / 4) % 3], (k / 4) % 3, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop_start_run k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    set_start(2'b00, 2, 0);
    for (int k = 0; k < 10; k++) begin
      if (k < 2)       exp_q.push_back(mk(mem_model[k], k, 1'b1, 1'b0));
      else if (k < 4)  exp_q.push_back(mk(8'h00, 0, 1'b0, 1'b0));
      else             exp_q.push_back(mk(8'h00, (k - 4) % 3, 1'b1, 1'b0));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0; rst = 1'b0;
      if (k == 1) begin
        // Reset must win over a simultaneous start and write.
        rst = 1'b1; bus.start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = 8'hAA;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
      end
      if (k == 3) set_start(2'b00, 2, 0);
      e = exp_q.pop_front(); o = {bus.seg_out, bus.index, bus.busy, bus.done};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid k=%0d got seg=%h idx=%0d busy=%b done=%b want seg=%h idx=%0d busy=%b done=%b",
                 k, o.seg, o.idx, o.busy, o.done, e.seg, e.idx, e.busy, e.done);
      end
    end
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_bounce();
    test_reverse_pause();
    test_stop_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
